// File: rtl/acc_mem_pkg.sv
// ============================================================================
// Module      : acc_mem_pkg
// Description : Shared types and default address windows for the accelerator
//               memory bridge and its address decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package acc_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        TGT_SPM = 2'd0,
        TGT_EXT = 2'd1,
        TGT_ERR = 2'd2
    } tgt_e;

    localparam logic [31:0] C_DEF_SPM_BASE  = 32'h0000_0000;
    localparam logic [31:0] C_DEF_SPM_SIZE  = 32'h0001_0000;
    localparam logic [31:0] C_DEF_EXT_BASE  = 32'hF000_0000;
    localparam logic [31:0] C_DEF_EXT_SIZE  = 32'h1000_0000;
    localparam logic [31:0] C_DEF_ERR_RDATA = 32'h0BAD_ADD0;

endpackage

`default_nettype wire

// File: rtl/acc_mem_decode.sv
// ============================================================================
// Module      : acc_mem_decode
// Description : Combinational address decoder selecting SPM, external or
//               unmapped target. SPM window takes priority over EXT window.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module acc_mem_decode
    import acc_mem_pkg::*;
#(
    parameter int                   ADDR_SIZE = 32,
    parameter logic [ADDR_SIZE-1:0] SPM_BASE  = C_DEF_SPM_BASE,
    parameter logic [ADDR_SIZE-1:0] SPM_SIZE  = C_DEF_SPM_SIZE,
    parameter logic [ADDR_SIZE-1:0] EXT_BASE  = C_DEF_EXT_BASE,
    parameter logic [ADDR_SIZE-1:0] EXT_SIZE  = C_DEF_EXT_SIZE
) (
    input  logic [ADDR_SIZE-1:0] i_addr,
    output tgt_e                 o_tgt
);

    logic [ADDR_SIZE-1:0] w_spm_off;
    logic [ADDR_SIZE-1:0] w_ext_off;

    // Subtract-then-compare handles windows anywhere in the space, unsigned wrap included.
    assign w_spm_off = i_addr - SPM_BASE;
    assign w_ext_off = i_addr - EXT_BASE;

    always_comb begin
        o_tgt = TGT_ERR;
        if (w_spm_off < SPM_SIZE) begin
            o_tgt = TGT_SPM;
        end else if (w_ext_off < EXT_SIZE) begin
            o_tgt = TGT_EXT;
        end
    end

endmodule

`default_nettype wire

// File: rtl/acc_mem_bridge.sv
// ============================================================================
// Module      : acc_mem_bridge
// Description : Routes the core's single-outstanding memory port to the SPM,
//               the external register port, or an unmapped-error path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module acc_mem_bridge
    import acc_mem_pkg::*;
#(
    parameter int                   DATA_SIZE = 32,
    parameter int                   ADDR_SIZE = 32,
    parameter logic [ADDR_SIZE-1:0] SPM_BASE  = C_DEF_SPM_BASE,
    parameter logic [ADDR_SIZE-1:0] SPM_SIZE  = C_DEF_SPM_SIZE,
    parameter logic [ADDR_SIZE-1:0] EXT_BASE  = C_DEF_EXT_BASE,
    parameter logic [ADDR_SIZE-1:0] EXT_SIZE  = C_DEF_EXT_SIZE,
    parameter logic [DATA_SIZE-1:0] ERR_RDATA = C_DEF_ERR_RDATA,
    localparam int                  STRB      = DATA_SIZE / 8,
    localparam int                  SPM_AW    = $clog2(SPM_SIZE) - 2
) (
    input  logic                 clk_i,
    input  logic                 resetn_i,

    input  logic                 core_en_i,
    input  logic [STRB-1:0]      core_we_i,
    input  logic [ADDR_SIZE-1:0] core_addr_i,
    input  logic [DATA_SIZE-1:0] core_wdata_i,
    output logic [DATA_SIZE-1:0] core_rdata_o,
    output logic                 core_stall_o,

    output logic                 spm_en_o,
    output logic [STRB-1:0]      spm_we_o,
    output logic [SPM_AW-1:0]    spm_addr_o,
    output logic [DATA_SIZE-1:0] spm_wdata_o,
    input  logic [DATA_SIZE-1:0] spm_rdata_i,

    output logic                 ext_req_valid_o,
    input  logic                 ext_req_ready_i,
    output logic [STRB-1:0]      ext_req_we_o,
    output logic [ADDR_SIZE-1:0] ext_req_addr_o,
    output logic [DATA_SIZE-1:0] ext_req_wdata_o,
    input  logic                 ext_rsp_valid_i,
    input  logic [DATA_SIZE-1:0] ext_rsp_rdata_i,
    input  logic                 ext_rsp_err_i,

    output logic                 err_o,
    output logic [ADDR_SIZE-1:0] err_addr_o,
    input  logic                 err_clr_i
);

    tgt_e                 w_tgt;
    state_e               r_state;
    state_e               w_state_nxt;
    logic                 r_resp;
    tgt_e                 r_src;
    logic [DATA_SIZE-1:0] r_ext_rdata;
    logic [STRB-1:0]      r_ext_we;
    logic [ADDR_SIZE-1:0] r_ext_addr;
    logic [DATA_SIZE-1:0] r_ext_wdata;
    logic                 r_err;
    logic [ADDR_SIZE-1:0] r_err_addr;

    logic                 w_stall;
    logic                 w_ext_valid;
    logic                 w_accept;
    logic                 w_spm_en;
    logic [ADDR_SIZE-1:0] w_spm_off;
    logic                 w_err_new;
    logic [ADDR_SIZE-1:0] w_err_addr;
    logic                 w_ext_start;

    acc_mem_decode #(
        .ADDR_SIZE (ADDR_SIZE),
        .SPM_BASE  (SPM_BASE),
        .SPM_SIZE  (SPM_SIZE),
        .EXT_BASE  (EXT_BASE),
        .EXT_SIZE  (EXT_SIZE)
    ) u_decode (
        .i_addr (core_addr_i),
        .o_tgt  (w_tgt)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_ext_start)     w_state_nxt = ST_REQ;
            ST_REQ:  if (ext_req_ready_i) w_state_nxt = ST_WAIT;
            ST_WAIT: if (ext_rsp_valid_i) w_state_nxt = ST_DONE;
            ST_DONE: if (w_accept)        w_state_nxt = ST_IDLE;
            default:                      w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Stall depends only on core inputs, state and r_resp; never on ext_* inputs.
    always_comb begin
        w_stall     = 1'b0;
        w_ext_valid = 1'b0;
        case (r_state)
            ST_IDLE: w_stall = core_en_i & ~r_resp & (w_tgt == TGT_EXT);
            ST_REQ: begin
                w_stall     = 1'b1;
                w_ext_valid = 1'b1;
            end
            ST_WAIT: w_stall = 1'b1;
            default: w_stall = 1'b0;
        endcase
    end

    assign w_ext_start = core_en_i & ~r_resp & (w_tgt == TGT_EXT);
    assign w_accept    = core_en_i & ~w_stall & ~r_resp;
    assign w_spm_en    = core_en_i & ~r_resp & (w_tgt == TGT_SPM);
    assign w_spm_off   = core_addr_i - SPM_BASE;

    assign w_err_new  = (w_accept & (w_tgt == TGT_ERR))
                      | ((r_state == ST_WAIT) & ext_rsp_valid_i & ext_rsp_err_i);
    assign w_err_addr = (r_state == ST_WAIT) ? (r_ext_addr + EXT_BASE) : core_addr_i;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_resp      <= 1'b0;
            r_src       <= TGT_SPM;
            r_ext_rdata <= '0;
            r_ext_we    <= '0;
            r_ext_addr  <= '0;
            r_ext_wdata <= '0;
            r_err       <= 1'b0;
            r_err_addr  <= '0;
        end else begin
            r_resp <= w_accept;
            if (w_accept) begin
                r_src <= w_tgt;
            end
            if ((r_state == ST_IDLE) && w_ext_start) begin
                r_ext_we    <= core_we_i;
                r_ext_addr  <= core_addr_i - EXT_BASE;
                r_ext_wdata <= core_wdata_i;
            end
            if ((r_state == ST_WAIT) && ext_rsp_valid_i) begin
                r_ext_rdata <= ext_rsp_err_i ? ERR_RDATA : ext_rsp_rdata_i;
            end
            // A simultaneous clear loses to a new error, which re-captures the address.
            if (w_err_new) begin
                r_err <= 1'b1;
                if (!r_err || err_clr_i) begin
                    r_err_addr <= w_err_addr;
                end
            end else if (err_clr_i) begin
                r_err <= 1'b0;
            end
        end
    end

    always_comb begin
        core_rdata_o = '0;
        if (r_resp) begin
            case (r_src)
                TGT_SPM: core_rdata_o = spm_rdata_i;
                TGT_EXT: core_rdata_o = r_ext_rdata;
                default: core_rdata_o = ERR_RDATA;
            endcase
        end
    end

    assign core_stall_o    = w_stall;
    assign spm_en_o        = w_spm_en;
    assign spm_we_o        = w_spm_en ? core_we_i : '0;
    assign spm_addr_o      = w_spm_en ? w_spm_off[SPM_AW+1:2] : '0;
    assign spm_wdata_o     = w_spm_en ? core_wdata_i : '0;
    assign ext_req_valid_o = w_ext_valid;
    assign ext_req_we_o    = r_ext_we;
    assign ext_req_addr_o  = r_ext_addr;
    assign ext_req_wdata_o = r_ext_wdata;
    assign err_o           = r_err;
    assign err_addr_o      = r_err_addr;

endmodule

`default_nettype wire

// File: tb/tb_acc_mem_bridge.sv
// ============================================================================
// Module      : tb_acc_mem_bridge
// Description : Directed self-checking bench for acc_mem_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_acc_mem_bridge;

    logic        clk_i = 1'b0;
    logic        resetn_i;
    logic        core_en_i;
    logic [3:0]  core_we_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wdata_i;
    logic [31:0] core_rdata_o;
    logic        core_stall_o;
    logic        spm_en_o;
    logic [3:0]  spm_we_o;
    logic [13:0] spm_addr_o;
    logic [31:0] spm_wdata_o;
    logic [31:0] spm_rdata_i;
    logic        ext_req_valid_o;
    logic        ext_req_ready_i;
    logic [3:0]  ext_req_we_o;
    logic [31:0] ext_req_addr_o;
    logic [31:0] ext_req_wdata_o;
    logic        ext_rsp_valid_i;
    logic [31:0] ext_rsp_rdata_i;
    logic        ext_rsp_err_i;
    logic        err_o;
    logic [31:0] err_addr_o;
    logic        err_clr_i;

    logic [31:0] r_spm_ret;
    int          n_checks = 0;
    int          n_errors = 0;

    acc_mem_bridge u_dut (
        .clk_i           (clk_i),
        .resetn_i        (resetn_i),
        .core_en_i       (core_en_i),
        .core_we_i       (core_we_i),
        .core_addr_i     (core_addr_i),
        .core_wdata_i    (core_wdata_i),
        .core_rdata_o    (core_rdata_o),
        .core_stall_o    (core_stall_o),
        .spm_en_o        (spm_en_o),
        .spm_we_o        (spm_we_o),
        .spm_addr_o      (spm_addr_o),
        .spm_wdata_o     (spm_wdata_o),
        .spm_rdata_i     (spm_rdata_i),
        .ext_req_valid_o (ext_req_valid_o),
        .ext_req_ready_i (ext_req_ready_i),
        .ext_req_we_o    (ext_req_we_o),
        .ext_req_addr_o  (ext_req_addr_o),
        .ext_req_wdata_o (ext_req_wdata_o),
        .ext_rsp_valid_i (ext_rsp_valid_i),
        .ext_rsp_rdata_i (ext_rsp_rdata_i),
        .ext_rsp_err_i   (ext_rsp_err_i),
        .err_o           (err_o),
        .err_addr_o      (err_addr_o),
        .err_clr_i       (err_clr_i)
    );

    always #5 clk_i = ~clk_i;

    // SPM model: synchronous read returns the programmed word one cycle after enable.
    always @(posedge clk_i) begin
        if (spm_en_o && (spm_we_o == 4'b0000)) spm_rdata_i <= r_spm_ret;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic en, input logic [3:0] we, input logic [31:0] addr,
                         input logic [31:0] wdata);
        core_en_i    = en;
        core_we_i    = we;
        core_addr_i  = addr;
        core_wdata_i = wdata;
        #1;
    endtask

    initial begin
        resetn_i        = 1'b0;
        core_en_i       = 1'b0;
        core_we_i       = '0;
        core_addr_i     = '0;
        core_wdata_i    = '0;
        spm_rdata_i     = '0;
        ext_req_ready_i = 1'b0;
        ext_rsp_valid_i = 1'b0;
        ext_rsp_rdata_i = '0;
        ext_rsp_err_i   = 1'b0;
        err_clr_i       = 1'b0;
        r_spm_ret       = 32'h1234_5678;

        // Reset state
        #12;
        check("rst_rdata", core_rdata_o, 32'h0);
        check("rst_stall", {31'h0, core_stall_o}, 32'h0);
        check("rst_err", {31'h0, err_o}, 32'h0);
        check("rst_err_addr", err_addr_o, 32'h0);
        check("rst_ext_valid", {31'h0, ext_req_valid_o}, 32'h0);
        resetn_i = 1'b1;
        tick();

        // SPM read
        drive(1'b1, 4'b0000, 32'h0000_0100, 32'h0);
        check("spm_rd_stall", {31'h0, core_stall_o}, 32'h0);
        check("spm_rd_en", {31'h0, spm_en_o}, 32'h1);
        check("spm_rd_addr", {18'h0, spm_addr_o}, 32'h40);
        tick();
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
        check("spm_rd_data", core_rdata_o, 32'h1234_5678);
        check("spm_rd_resp_stall", {31'h0, core_stall_o}, 32'h0);
        tick();

        // SPM write at top of window
        drive(1'b1, 4'b0011, 32'h0000_FFFC, 32'hA1B2_C3D4);
        check("spm_wr_stall", {31'h0, core_stall_o}, 32'h0);
        check("spm_wr_we", {28'h0, spm_we_o}, 32'h3);
        check("spm_wr_addr", {18'h0, spm_addr_o}, 32'h3FFF);
        check("spm_wr_wdata", spm_wdata_o, 32'hA1B2_C3D4);
        tick();
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
        check("spm_wr_resp_en", {31'h0, spm_en_o}, 32'h0);
        tick();

        // EXT read, ready delayed 2 cycles, response 3 cycles later
        drive(1'b1, 4'b0000, 32'hF000_0010, 32'h0);
        check("ext_c0_stall", {31'h0, core_stall_o}, 32'h1);
        check("ext_c0_valid", {31'h0, ext_req_valid_o}, 32'h0);
        tick();
        check("ext_req_valid", {31'h0, ext_req_valid_o}, 32'h1);
        check("ext_req_addr", ext_req_addr_o, 32'h10);
        tick();
        tick();
        check("ext_req_held", {31'h0, ext_req_valid_o}, 32'h1);
        check("ext_req_addr_held", ext_req_addr_o, 32'h10);
        ext_req_ready_i = 1'b1;
        tick();
        ext_req_ready_i = 1'b0;
        check("ext_wait_valid", {31'h0, ext_req_valid_o}, 32'h0);
        check("ext_wait_stall", {31'h0, core_stall_o}, 32'h1);
        tick();
        tick();
        ext_rsp_valid_i = 1'b1;
        ext_rsp_rdata_i = 32'hCAFE_0001;
        tick();
        ext_rsp_valid_i = 1'b0;
        ext_rsp_rdata_i = 32'h0;
        check("ext_done_stall", {31'h0, core_stall_o}, 32'h0);
        tick();
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
        check("ext_rd_data", core_rdata_o, 32'hCAFE_0001);
        tick();

        // Unmapped read and sticky error address
        drive(1'b1, 4'b0000, 32'h8000_0000, 32'h0);
        check("err_stall", {31'h0, core_stall_o}, 32'h0);
        check("err_spm_en", {31'h0, spm_en_o}, 32'h0);
        tick();
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
        check("err_rdata", core_rdata_o, 32'h0BAD_ADD0);
        check("err_flag", {31'h0, err_o}, 32'h1);
        check("err_addr", err_addr_o, 32'h8000_0000);
        tick();
        drive(1'b1, 4'b0000, 32'h9000_0000, 32'h0);
        tick();
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
        check("err_addr_kept", err_addr_o, 32'h8000_0000);
        tick();
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        check("err_cleared", {31'h0, err_o}, 32'h0);

        // EXT error response with immediate ready and response
        drive(1'b1, 4'b0000, 32'hF000_0020, 32'h0);
        ext_req_ready_i = 1'b1;
        tick();
        tick();
        ext_req_ready_i = 1'b0;
        ext_rsp_valid_i = 1'b1;
        ext_rsp_err_i   = 1'b1;
        tick();
        ext_rsp_valid_i = 1'b0;
        ext_rsp_err_i   = 1'b0;
        tick();
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
        check("ext_err_rdata", core_rdata_o, 32'h0BAD_ADD0);
        check("ext_err_flag", {31'h0, err_o}, 32'h1);
        check("ext_err_addr", err_addr_o, 32'hF000_0020);
        tick();
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;

        // Reset pulse while waiting for a response
        drive(1'b1, 4'b0000, 32'hF000_0030, 32'h0);
        ext_req_ready_i = 1'b1;
        tick();
        tick();
        ext_req_ready_i = 1'b0;
        check("rstw_stall", {31'h0, core_stall_o}, 32'h1);
        #2;
        resetn_i = 1'b0;
        #1;
        check("rstw_valid", {31'h0, ext_req_valid_o}, 32'h0);
        check("rstw_rdata", core_rdata_o, 32'h0);
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
        check("rstw_stall_idle", {31'h0, core_stall_o}, 32'h0);
        tick();
        resetn_i        = 1'b1;
        ext_rsp_valid_i = 1'b1;
        ext_rsp_rdata_i = 32'hDEAD_BEEF;
        tick();
        ext_rsp_valid_i = 1'b0;
        ext_rsp_rdata_i = 32'h0;
        check("late_rsp_rdata", core_rdata_o, 32'h0);
        check("late_rsp_valid", {31'h0, ext_req_valid_o}, 32'h0);
        check("late_rsp_err", {31'h0, err_o}, 32'h0);
        r_spm_ret = 32'hA5A5_5A5A;
        drive(1'b1, 4'b0000, 32'h0000_0200, 32'h0);
        check("post_rst_stall", {31'h0, core_stall_o}, 32'h0);
        check("post_rst_addr", {18'h0, spm_addr_o}, 32'h80);
        tick();
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
        check("post_rst_data", core_rdata_o, 32'hA5A5_5A5A);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
